// File: rtl/i2c_target_core.sv
// I2C target with an auto-incrementing byte register file.
// Bus sampled through synchronizers; SDA driven open-drain via sda_oe_o.
`timescale 1ns/1ps
module i2c_target_core #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          i2c_core_clk_i,
   input  logic          i2c_core_rst_i,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe_o,
   input  logic [AW-1:0] reg_raddr_i,
   output logic [7:0]    reg_rdata_o,
   output logic          wr_valid_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [7:0]    wr_data_o,
   output logic          busy_o
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA,
      WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   state_t        state;
   logic          scl_s1, scl_s2, scl_d;
   logic          sda_s1, sda_s2, sda_d;
   logic [7:0]    regs [DEPTH];
   logic [7:0]    shift;
   logic [3:0]    bit_cnt;
   logic [AW-1:0] ptr;
   logic          ptr_load;

   logic          scl_rise, scl_fall;
   logic          start_det, stop_det;
   logic [7:0]    rx_byte, rd_byte;

   // Synchronizers track the pads and are left out of reset so that a
   // reset mid-transfer cannot fabricate a START/STOP from stale history.
   always_ff @(posedge i2c_core_clk_i) begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
   end

   // START/STOP need SCL high in both samples; a coincident edge is data.
   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
   assign rx_byte   = {shift[6:0], sda_s2};
   assign rd_byte   = regs[ptr];
   assign reg_rdata_o = regs[reg_raddr_i];

   always_ff @(posedge i2c_core_clk_i) begin
      if (i2c_core_rst_i) begin
         state      <= IDLE;
         sda_oe_o   <= 1'b0;
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
         busy_o     <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         ptr        <= '0;
         ptr_load   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         wr_valid_o <= 1'b0;
         if (start_det) begin
            state    <= ADDR;
            bit_cnt  <= '0;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b1;
         end else if (stop_det) begin
            state    <= IDLE;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
         end else begin
            unique case (state)
               IDLE, WAIT_STOP: sda_oe_o <= 1'b0;
               ADDR: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     if (shift[7:1] == SLAVE_ADDR) begin
                        state    <= ADDR_ACK;
                        sda_oe_o <= 1'b1;
                     end else begin
                        state <= WAIT_STOP;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (shift[0]) begin
                        state    <= RD_DATA;
                        shift    <= rd_byte;
                        sda_oe_o <= ~rd_byte[7];
                        bit_cnt  <= 4'd1;
                     end else begin
                        state    <= WR_DATA;
                        sda_oe_o <= 1'b0;
                        bit_cnt  <= '0;
                        ptr_load <= 1'b1;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        if (ptr_load) begin
                           ptr      <= rx_byte[AW-1:0];
                           ptr_load <= 1'b0;
                        end else begin
                           regs[ptr]  <= rx_byte;
                           wr_valid_o <= 1'b1;
                           wr_addr_o  <= ptr;
                           wr_data_o  <= rx_byte;
                           ptr        <= ptr + 1'b1;
                        end
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     state    <= WR_ACK;
                     sda_oe_o <= 1'b1;
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     state    <= WR_DATA;
                     sda_oe_o <= 1'b0;
                     bit_cnt  <= '0;
                  end
               end
               RD_DATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        state    <= RD_ACK;
                        sda_oe_o <= 1'b0;
                     end else begin
                        shift    <= {shift[6:0], 1'b0};
                        sda_oe_o <= ~shift[6];
                        bit_cnt  <= bit_cnt + 4'd1;
                     end
                  end
               end
               RD_ACK: begin
                  // A falling edge here always follows an ACKed rise.
                  if (scl_rise) begin
                     if (sda_s2) state <= WAIT_STOP;
                     else        ptr   <= ptr + 1'b1;
                  end else if (scl_fall) begin
                     state    <= RD_DATA;
                     shift    <= rd_byte;
                     sda_oe_o <= ~rd_byte[7];
                     bit_cnt  <= 4'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule
